sram_bist_ctrl: RTL and testbench

SRAM_BIST_CTRL -- requirements
Module: sram_bist_ctrl

---
 rtl/sram_bist_ctrl.sv | 141 ++++++++++++++
 tb/tb_sram_bist_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/sram_bist_ctrl.sv
// sram_bist_ctrl: March C- BIST sequencer for a single-port SRAM macro, with first-failure capture.
// bist_en rises one setup cycle ahead of the first access; the final M5 read is checked in DRAIN.
module sram_bist_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic [DATA_W-1:0] fail_bits,
    output logic              bist_en,
    output logic              bist_men,
    output logic              bist_wen,
    output logic              bist_ren,
    output logic [ADDR_W-1:0] bist_addr,
    output logic [DATA_W-1:0] bist_din,
    output logic [DATA_W-1:0] bist_bm,
    input  logic [DATA_W-1:0] bist_dout
);
    typedef enum logic [3:0] {M0, M1, M2, M3, M4, M5, DRAIN, DONE, IDLE} state_t;

    localparam logic [ADDR_W-1:0] LAST = '1;

    state_t state, nxt;
    logic arm, n_arm, ph, n_ph;
    logic up, at_end, n_acc, n_wen, n_ren, n_din1, n_exp1, n_en;
    logic [ADDR_W-1:0] step, n_addr, chk_addr;
    logic rd_exp, chk_v, chk_exp, fail, mism;
    logic [2:0] rd_elem, chk_elem;
    logic [DATA_W-1:0] diff;

    assign busy = !(state inside {IDLE, DONE});
    assign done = state == DONE;

    always_comb begin
        up     = state inside {M0, M1, M2};
        step   = up ? bist_addr + ADDR_W'(1) : bist_addr - ADDR_W'(1);
        at_end = up ? bist_addr == LAST : bist_addr == '0;
        nxt    = state;
        n_addr = bist_addr;
        n_ph   = ph;
        n_arm  = 1'b0;
        case (state)
            IDLE, DONE: if (start) begin
                nxt    = M0;
                n_addr = '0;
                n_ph   = 1'b0;
                n_arm  = 1'b1;
            end
            M0: if (!arm) begin
                n_addr = step;
                nxt    = at_end ? M1 : M0;
            end
            // Read/write pairs: the address only moves after the write half
            M1, M2, M3, M4: begin
                n_ph = ~ph;
                if (ph) begin
                    n_addr = (state == M2 && at_end) ? bist_addr : step;
                    if (at_end)
                        nxt = state == M1 ? M2 : state == M2 ? M3 : state == M3 ? M4 : M5;
                end
            end
            M5: begin
                n_addr = step;
                nxt    = at_end ? DRAIN : M5;
            end
            DRAIN: nxt = DONE;
            default: nxt = IDLE;
        endcase
        n_acc  = nxt inside {M0, M1, M2, M3, M4, M5} && !n_arm;
        n_wen  = n_acc && (nxt == M0 || n_ph);
        n_ren  = n_acc && !n_wen;
        n_din1 = nxt inside {M1, M3};
        n_exp1 = nxt inside {M2, M4};
        n_en   = !(nxt inside {DONE, IDLE});
        diff   = bist_dout ^ {DATA_W{chk_exp}};
        mism   = chk_v && diff != '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ph        <= 1'b0;
            arm       <= 1'b0;
            bist_en   <= 1'b0;
            bist_men  <= 1'b0;
            bist_wen  <= 1'b0;
            bist_ren  <= 1'b0;
            bist_addr <= '0;
            bist_din  <= '0;
            bist_bm   <= '0;
            rd_exp    <= 1'b0;
            rd_elem   <= '0;
            chk_v     <= 1'b0;
            chk_exp   <= 1'b0;
            chk_elem  <= '0;
            chk_addr  <= '0;
            fail      <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
            fail_bits <= '0;
        end else begin
            state     <= nxt;
            ph        <= n_ph;
            arm       <= n_arm;
            bist_en   <= n_en;
            bist_men  <= n_acc;
            bist_wen  <= n_wen;
            bist_ren  <= n_ren;
            bist_addr <= n_addr;
            bist_din  <= {DATA_W{n_wen && n_din1}};
            bist_bm   <= {DATA_W{n_wen}};
            rd_exp    <= n_exp1;
            rd_elem   <= nxt[2:0];
            chk_v     <= bist_ren;
            chk_exp   <= rd_exp;
            chk_elem  <= rd_elem;
            chk_addr  <= bist_addr;
            if (state inside {IDLE, DONE} && start) begin
                fail      <= 1'b0;
                pass      <= 1'b0;
                fail_addr <= '0;
                fail_elem <= '0;
                fail_bits <= '0;
            end else if (mism && !fail) begin
                fail      <= 1'b1;
                fail_addr <= chk_addr;
                fail_elem <= chk_elem;
                fail_bits <= diff;
            end
            if (state == DRAIN)
                pass <= !(fail || mism);
        end
    end
endmodule

// File: tb/tb_sram_bist_ctrl.sv
// tb_sram_bist_ctrl: directed checks of sram_bist_ctrl against a behavioural SRAM with injectable faults.
// mode 0 = fault-free, 1 = bit 5 of 0x155 stuck-at-1, 2 = writes to 0x3FF also land on 0x000.
module tb_sram_bist_ctrl;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int N  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, pass;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;
    logic [DW-1:0] fail_bits;
    logic          bist_en, bist_men, bist_wen, bist_ren;
    logic [AW-1:0] bist_addr;
    logic [DW-1:0] bist_din, bist_bm;
    logic [DW-1:0] bist_dout = '0;

    logic [DW-1:0] mem [N];
    int            mode = 0;
    int            n_tests = 0;
    int            n_fail = 0;
    int            bcnt, mcnt;
    logic [AW-1:0] a_first, a_m2, a_m3;
    logic          w_first;

    sram_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
        .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_bits(fail_bits),
        .bist_en(bist_en), .bist_men(bist_men), .bist_wen(bist_wen), .bist_ren(bist_ren),
        .bist_addr(bist_addr), .bist_din(bist_din), .bist_bm(bist_bm), .bist_dout(bist_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bist_men && bist_wen) begin
            mem[bist_addr] <= (bist_din & bist_bm) | (mem[bist_addr] & ~bist_bm);
            if (mode == 2 && bist_addr == 10'h3FF)
                mem[0] <= (bist_din & bist_bm) | (mem[bist_addr] & ~bist_bm);
        end
        if (bist_men && bist_ren)
            bist_dout <= mem[bist_addr] | ((mode == 1 && bist_addr == 10'h155) ? 32'h20 : 32'h0);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input bit hold);
        bcnt  = 0;
        mcnt  = 0;
        start = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (busy) bcnt++;
            if (bist_men) begin
                if (mcnt == 0) begin
                    a_first = bist_addr;
                    w_first = bist_wen;
                end
                if (mcnt == 5 * N - 1) a_m2 = bist_addr;
                if (mcnt == 5 * N) a_m3 = bist_addr;
                mcnt++;
            end
            if (done) break;
        end
        chk("done_reached", done, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_en", bist_en, 0);
        chk("rst_men", bist_men, 0);
        chk("rst_fail_addr", fail_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);

        mode = 0;
        run(0);
        chk("clean_busy_cycles", bcnt, 10242);
        chk("clean_pass", pass, 1);
        chk("clean_fail_addr", fail_addr, 0);
        chk("clean_men_cycles", mcnt, 10240);
        chk("first_addr", a_first, 0);
        chk("first_is_write", w_first, 1);
        chk("last_m2_addr", a_m2, 10'h3FF);
        chk("first_m3_addr", a_m3, 10'h3FF);
        chk("done_en_low", bist_en, 0);
        chk("done_men_low", bist_men, 0);

        mode = 1;
        run(0);
        chk("stuck_pass", pass, 0);
        chk("stuck_addr", fail_addr, 10'h155);
        chk("stuck_elem", fail_elem, 1);
        chk("stuck_bits", fail_bits, 32'h20);
        chk("stuck_busy_cycles", bcnt, 10242);

        mode = 2;
        run(0);
        chk("couple_pass", pass, 0);
        chk("couple_addr", fail_addr, 0);
        chk("couple_elem", fail_elem, 3);
        chk("couple_bits", fail_bits, 32'hFFFF_FFFF);

        mode = 0;
        mcnt  = 0;
        start = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (bist_men) mcnt++;
            if (mcnt == 5000) break;
        end
        chk("mid_ops_reached", mcnt, 5000);
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_en", bist_en, 0);
        chk("midrst_men", bist_men, 0);
        chk("midrst_fail_elem", fail_elem, 0);
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", busy, 0);
        run(0);
        chk("post_rst_pass", pass, 1);
        chk("post_rst_busy_cycles", bcnt, 10242);

        run(1);
        chk("held_busy_cycles", bcnt, 10242);
        chk("held_pass", pass, 1);
        @(negedge clk);
        chk("restart_busy", busy, 1);
        chk("restart_done", done, 0);
        run(0);
        chk("restart_remaining", bcnt, 10241);
        chk("restart_pass", pass, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
